// File: rtl/sb_pkg.sv
// Shared types and defaults for the stream-buffer read arbiter.
package sb_pkg;

  localparam int SB_N_REQ     = 8;
  localparam int SB_LINE_SIZE = 4;
  localparam int SB_ADDR_W    = 32;
  localparam int SB_DATA_W    = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_ADDR = 1'b1
  } arb_state_t;

  function automatic int sb_id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request bit at or after i_ptr, wrapping.
module rr_picker #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_grant_valid,
  output logic [IW-1:0] o_grant_idx
);

  logic [IW-1:0] w_cand;

  // N is a power of two, so IW-bit addition wraps the search naturally
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_cand        = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = i_ptr + IW'(i);
      if (!o_grant_valid && i_req[w_cand]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/sb_read_arbiter.sv
// Shares one AXI read port among stream-buffer cells: round-robin AR grants tagged
// with the requester index, R beats steered back to their owner by RID.
//   state    | meaning
//   ARB_IDLE | choose next eligible requester, latch its index and address
//   ARB_ADDR | present the latched address to memory until mem_arready
module sb_read_arbiter
  import sb_pkg::*;
#(
  parameter int N_REQ     = SB_N_REQ,
  parameter int LINE_SIZE = SB_LINE_SIZE,
  parameter int ADDR_W    = SB_ADDR_W,
  parameter int DATA_W    = SB_DATA_W,
  parameter int ID_W      = sb_id_w(N_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req_arvalid,
  input  logic [N_REQ*ADDR_W-1:0] i_req_araddr,
  output logic [N_REQ-1:0]        o_req_arready,
  output logic [N_REQ-1:0]        o_req_rvalid,
  output logic [DATA_W-1:0]       o_req_rdata,
  output logic                    o_req_rlast,
  input  logic [N_REQ-1:0]        i_req_rready,
  output logic                    o_mem_arvalid,
  input  logic                    i_mem_arready,
  output logic [ADDR_W-1:0]       o_mem_araddr,
  output logic [ID_W-1:0]         o_mem_arid,
  output logic [7:0]              o_mem_arlen,
  input  logic                    i_mem_rvalid,
  output logic                    o_mem_rready,
  input  logic [DATA_W-1:0]       i_mem_rdata,
  input  logic [ID_W-1:0]         i_mem_rid,
  input  logic                    i_mem_rlast,
  output logic                    o_drop_pulse
);

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  arb_state_t          r_state, w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic [N_REQ-1:0]    r_outstanding;

  logic [N_REQ-1:0]    w_eligible;
  logic                w_grant_valid;
  logic [ID_W-1:0]     w_grant_idx;
  logic [ADDR_W-1:0]   w_grant_addr;
  logic                w_ar_fire;
  logic                w_r_fire;
  logic                w_rid_out;
  logic [N_REQ-1:0]    w_owner_oh;
  logic [N_REQ-1:0]    w_rid_oh;
  logic [N_REQ-1:0]    w_set;
  logic [N_REQ-1:0]    w_clr;

  assign w_eligible   = i_req_arvalid & ~r_outstanding;
  assign w_grant_addr = i_req_araddr[w_grant_idx*ADDR_W +: ADDR_W];

  rr_picker #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_rr_picker (
    .i_req         (w_eligible),
    .i_ptr         (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (w_grant_valid) w_state_nxt = ARB_ADDR;
      ARB_ADDR: if (i_mem_arready) w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  // Handshakes are masked during reset so no pulse escapes a reset cycle
  assign w_ar_fire  = (r_state == ARB_ADDR) && i_mem_arready && !i_rst;
  assign w_owner_oh = ONE << r_owner;
  assign w_rid_oh   = ONE << i_mem_rid;
  assign w_rid_out  = r_outstanding[i_mem_rid];

  assign o_mem_rready = w_rid_out ? i_req_rready[i_mem_rid] : 1'b1;
  assign w_r_fire     = i_mem_rvalid && o_mem_rready;
  assign w_set        = w_ar_fire ? w_owner_oh : '0;
  assign w_clr        = (w_r_fire && i_mem_rlast) ? w_rid_oh : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ARB_IDLE;
      r_rr_ptr      <= '0;
      r_owner       <= '0;
      r_addr        <= '0;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= (r_outstanding & ~w_clr) | w_set;
      if (r_state == ARB_IDLE && w_grant_valid) begin
        r_owner <= w_grant_idx;
        r_addr  <= w_grant_addr;
      end
      if (w_ar_fire) r_rr_ptr <= r_owner + 1'b1;
    end
  end

  assign o_mem_arvalid = (r_state == ARB_ADDR);
  assign o_mem_araddr  = r_addr;
  assign o_mem_arid    = r_owner;
  assign o_mem_arlen   = 8'(LINE_SIZE - 1);
  assign o_req_arready = w_ar_fire ? w_owner_oh : '0;

  assign o_req_rvalid  = (i_mem_rvalid && w_rid_out) ? w_rid_oh : '0;
  assign o_req_rdata   = i_mem_rdata;
  assign o_req_rlast   = i_mem_rlast;
  assign o_drop_pulse  = i_mem_rvalid && !w_rid_out && !i_rst;

endmodule
